calib_shot_sequencer: RTL and testbench

- Sequences a multi-shot calibration run: issues start pulses to the calibration FSM, waits for completion, applies an inter-shot holdoff, and steps the phase-shift value handed to the FSM on each shot (phase scan).
- Retries failed shots (detector-ready timeout) up to a limit, then flags a fault.
- Sits between the host/control register block and the calibration FSM; owns that FSM's start/abort strobes and its phase-shift parameter.

---
 rtl/calib_shot_sequencer_if.sv | 44 ++++
 rtl/calib_shot_sequencer.sv | 131 +++++++++++++
 tb/tb_calib_shot_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/calib_shot_sequencer_if.sv
// Host/config and calibration-FSM signal bundle for calib_shot_sequencer.
// slave is the sequencer view; master is the host plus calibration FSM view.
interface calib_shot_sequencer_if #(
    parameter int PHASE_W = 32,
    parameter int CNT_W   = 16,
    parameter int HOLD_W  = 32
);
    logic               cmd_start;
    logic               cmd_abort;
    logic [CNT_W-1:0]   shot_total;
    logic [PHASE_W-1:0] phase_base;
    logic [PHASE_W-1:0] phase_step;
    logic [HOLD_W-1:0]  holdoff;
    logic               fsm_busy;
    logic               fsm_done;
    logic               fsm_error;
    logic               fsm_start;
    logic               fsm_abort;
    logic [PHASE_W-1:0] phase_shift;
    logic [CNT_W-1:0]   shot_idx;
    logic [3:0]         retry_cnt;
    logic               seq_busy;
    logic               seq_done;
    logic               seq_aborted;
    logic               seq_fault;

    modport slave (
        input  cmd_start, cmd_abort, shot_total,
        input  phase_base, phase_step, holdoff,
        input  fsm_busy, fsm_done, fsm_error,
        output fsm_start, fsm_abort, phase_shift,
        output shot_idx, retry_cnt, seq_busy,
        output seq_done, seq_aborted, seq_fault
    );

    modport master (
        output cmd_start, cmd_abort, shot_total,
        output phase_base, phase_step, holdoff,
        output fsm_busy, fsm_done, fsm_error,
        input  fsm_start, fsm_abort, phase_shift,
        input  shot_idx, retry_cnt, seq_busy,
        input  seq_done, seq_aborted, seq_fault
    );
endinterface

// File: rtl/calib_shot_sequencer.sv
// Multi-shot calibration run sequencer: start/ack/holdoff per shot,
// phase scan across shots, bounded retries and sticky fault.
module calib_shot_sequencer #(
    parameter int PHASE_W     = 32,
    parameter int CNT_W       = 16,
    parameter int HOLD_W      = 32,
    parameter int ACK_TIMEOUT = 64,
    parameter int MAX_RETRY   = 3
) (
    input logic clock,
    input logic reset,
    calib_shot_sequencer_if.slave bus
);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_RUN,
        S_HOLDOFF,
        S_DONE,
        S_FAULT
    } state_t;

    state_t             state, state_n;
    logic [ACK_W-1:0]   ack_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]   cfg_total;
    logic [PHASE_W-1:0] cfg_step;
    logic [HOLD_W-1:0]  cfg_hold;

    logic busy_st, abort_go, run_go, in_shot;
    logic shot_ok, shot_fail, can_retry, last_shot, to_fault;

    always_comb begin
        busy_st   = state != S_IDLE && state != S_FAULT;
        abort_go  = bus.cmd_abort && busy_st;
        run_go    = bus.cmd_start && !busy_st;
        in_shot   = state == S_WAIT_ACK || state == S_RUN;
        // Error beats done; busy beats a same-cycle ack timeout.
        shot_fail = in_shot && bus.fsm_error;
        if (state == S_WAIT_ACK && !bus.fsm_busy
            && ack_cnt == ACK_W'(ACK_TIMEOUT - 1))
            shot_fail = 1'b1;
        shot_ok   = in_shot && bus.fsm_done && !shot_fail;
        can_retry = bus.retry_cnt < 4'(MAX_RETRY);
        last_shot = bus.shot_idx == cfg_total - CNT_W'(1);
        to_fault  = shot_fail && !can_retry && !abort_go;

        state_n = state;
        unique case (state)
            S_IDLE, S_FAULT: begin
                if (bus.cmd_start)
                    state_n = (bus.shot_total == '0) ? S_DONE : S_START;
            end
            S_START: state_n = S_WAIT_ACK;
            S_WAIT_ACK, S_RUN: begin
                if (shot_fail)
                    state_n = can_retry ? S_HOLDOFF : S_FAULT;
                else if (shot_ok)
                    state_n = last_shot ? S_DONE : S_HOLDOFF;
                else if (state == S_WAIT_ACK && bus.fsm_busy)
                    state_n = S_RUN;
            end
            S_HOLDOFF: begin
                if (hold_cnt == cfg_hold)
                    state_n = S_START;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort_go)
            state_n = S_IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_cnt         <= '0;
            hold_cnt        <= '0;
            cfg_total       <= '0;
            cfg_step        <= '0;
            cfg_hold        <= '0;
            bus.fsm_start   <= 1'b0;
            bus.fsm_abort   <= 1'b0;
            bus.phase_shift <= '0;
            bus.shot_idx    <= '0;
            bus.retry_cnt   <= '0;
            bus.seq_busy    <= 1'b0;
            bus.seq_done    <= 1'b0;
            bus.seq_aborted <= 1'b0;
            bus.seq_fault   <= 1'b0;
        end else begin
            ack_cnt  <= (state == S_WAIT_ACK) ? ack_cnt + 1'b1 : '0;
            hold_cnt <= (state == S_HOLDOFF) ? hold_cnt + 1'b1 : '0;

            bus.fsm_start   <= state_n == S_START;
            bus.fsm_abort   <= abort_go || to_fault;
            bus.seq_busy    <= state_n != S_IDLE && state_n != S_FAULT;
            bus.seq_done    <= state == S_DONE && !abort_go;
            bus.seq_aborted <= abort_go;

            if (run_go) begin
                cfg_total       <= bus.shot_total;
                cfg_step        <= bus.phase_step;
                cfg_hold        <= bus.holdoff;
                bus.phase_shift <= bus.phase_base;
                bus.shot_idx    <= '0;
                bus.retry_cnt   <= '0;
                bus.seq_fault   <= 1'b0;
            end else if (!abort_go) begin
                if (to_fault)
                    bus.seq_fault <= 1'b1;
                if (shot_fail && can_retry)
                    bus.retry_cnt <= bus.retry_cnt + 1'b1;
                if (shot_ok && !last_shot) begin
                    bus.shot_idx    <= bus.shot_idx + 1'b1;
                    bus.phase_shift <= bus.phase_shift + cfg_step;
                    bus.retry_cnt   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_calib_shot_sequencer.sv
// Directed bench for calib_shot_sequencer with a small calibration FSM model.
// Inputs change on negedge; outputs are sampled on negedge or 1ns after posedge.
module tb_calib_shot_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calib_shot_sequencer_if #(.PHASE_W(32), .CNT_W(16), .HOLD_W(32)) bus();

    calib_shot_sequencer #(
        .PHASE_W(32), .CNT_W(16), .HOLD_W(32),
        .ACK_TIMEOUT(64), .MAX_RETRY(3)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Calibration FSM model
    int ack_dly = 2;
    int run_len = 5;
    int errs_left = 0;
    bit never_ack = 0;
    bit both = 0;
    int mcnt = 0;
    bit mact = 0;

    always @(negedge clk) begin
        bus.fsm_done = 1'b0;
        bus.fsm_error = 1'b0;
        if (!rst_n || bus.fsm_abort) begin
            mact = 0;
            bus.fsm_busy = 1'b0;
        end else if (bus.fsm_start) begin
            mact = 1;
            mcnt = 0;
        end else if (mact && !never_ack) begin
            mcnt++;
            if (mcnt == ack_dly)
                bus.fsm_busy = 1'b1;
            if (mcnt == ack_dly + run_len) begin
                bus.fsm_busy = 1'b0;
                mact = 0;
                if (errs_left > 0) begin
                    bus.fsm_error = 1'b1;
                    bus.fsm_done = both;
                    errs_left--;
                end else begin
                    bus.fsm_done = 1'b1;
                end
            end
        end
    end

    // Output monitor
    int cyc = 0;
    int n_start = 0, n_done = 0, n_abort = 0, n_aborted = 0;
    logic [31:0] st_phase [8];
    logic [3:0]  st_retry [8];
    int          st_cyc   [8];

    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.fsm_start) begin
            if (n_start < 8) begin
                st_phase[n_start] = bus.phase_shift;
                st_retry[n_start] = bus.retry_cnt;
                st_cyc[n_start] = cyc;
            end
            n_start++;
        end
        if (bus.fsm_abort) n_abort++;
        if (bus.seq_done) n_done++;
        if (bus.seq_aborted) n_aborted++;
    end

    task automatic clr();
        n_start = 0;
        n_done = 0;
        n_abort = 0;
        n_aborted = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int tot, input logic [31:0] base,
                       input logic [31:0] step, input int hold);
        bus.shot_total = 16'(tot);
        bus.phase_base = base;
        bus.phase_step = step;
        bus.holdoff = 32'(hold);
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.cmd_start = 1'b1;
        @(negedge clk) bus.cmd_start = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int lim);
        int k = 0;
        while (n_start < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("wait_starts", 64'(n_start), 64'(n));
    endtask

    function automatic logic [5:0] flags();
        return {bus.fsm_start, bus.fsm_abort, bus.seq_busy,
                bus.seq_done, bus.seq_aborted, bus.seq_fault};
    endfunction

    initial begin
        bus.cmd_start = 0;
        bus.cmd_abort = 0;
        bus.fsm_busy = 0;
        bus.fsm_done = 0;
        bus.fsm_error = 0;
        cfg(0, 0, 0, 0);
        cycles(3);
        chk("rst_flags", 64'(flags()), 64'h0);
        chk("rst_phase", 64'(bus.phase_shift), 64'h0);
        rst_n = 1'b1;
        cycles(2);
        chk("idle_flags", 64'(flags()), 64'h0);
        chk("idle_idx", 64'(bus.shot_idx), 64'h0);

        // Three clean shots with phase scan
        ack_dly = 2; run_len = 50;
        cfg(3, 100, 20, 10);
        clr();
        pulse_start();
        cfg(7, 999, 999, 0);
        cycles(260);
        chk("t1_starts", 64'(n_start), 64'd3);
        chk("t1_ph0", 64'(st_phase[0]), 64'd100);
        chk("t1_ph1", 64'(st_phase[1]), 64'd120);
        chk("t1_ph2", 64'(st_phase[2]), 64'd140);
        chk("t1_gap", 64'(st_cyc[1] - st_cyc[0]), 64'd64);
        chk("t1_gap2", 64'(st_cyc[2] - st_cyc[1]), 64'd64);
        chk("t1_done", 64'(n_done), 64'd1);
        chk("t1_fault", 64'(bus.seq_fault), 64'd0);
        chk("t1_idx", 64'(bus.shot_idx), 64'd2);
        chk("t1_phase", 64'(bus.phase_shift), 64'd140);
        chk("t1_busy", 64'(bus.seq_busy), 64'd0);

        // Two errors (done+error together) on shot 0, then success
        run_len = 5; errs_left = 2; both = 1;
        cfg(2, 500, 7, 3);
        clr();
        pulse_start();
        cycles(120);
        chk("t2_starts", 64'(n_start), 64'd4);
        chk("t2_ph0", 64'(st_phase[0]), 64'd500);
        chk("t2_ph1", 64'(st_phase[1]), 64'd500);
        chk("t2_ph2", 64'(st_phase[2]), 64'd500);
        chk("t2_ph3", 64'(st_phase[3]), 64'd507);
        chk("t2_rt1", 64'(st_retry[1]), 64'd1);
        chk("t2_rt2", 64'(st_retry[2]), 64'd2);
        chk("t2_rt3", 64'(st_retry[3]), 64'd0);
        chk("t2_done", 64'(n_done), 64'd1);
        chk("t2_idx", 64'(bus.shot_idx), 64'd1);
        both = 0;

        // No ack ever: four timed-out attempts then fault
        never_ack = 1;
        cfg(1, 33, 1, 0);
        clr();
        pulse_start();
        cycles(320);
        chk("t3_starts", 64'(n_start), 64'd4);
        chk("t3_gap", 64'(st_cyc[1] - st_cyc[0]), 64'd66);
        chk("t3_fault", 64'(bus.seq_fault), 64'd1);
        chk("t3_abort", 64'(n_abort), 64'd1);
        chk("t3_retry", 64'(bus.retry_cnt), 64'd3);
        chk("t3_busy", 64'(bus.seq_busy), 64'd0);
        chk("t3_done", 64'(n_done), 64'd0);
        never_ack = 0;
        clr();
        pulse_start();
        chk("t3_clr", 64'(bus.seq_fault), 64'd0);
        chk("t3_rbusy", 64'(bus.seq_busy), 64'd1);
        cycles(40);
        chk("t3_rdone", 64'(n_done), 64'd1);

        // Abort during shot 1 of 5
        run_len = 50;
        cfg(5, 10, 5, 10);
        clr();
        pulse_start();
        wait_starts(2, 200);
        cycles(20);
        @(negedge clk) bus.cmd_abort = 1'b1;
        @(negedge clk) bus.cmd_abort = 1'b0;
        chk("t4_fabort", 64'(bus.fsm_abort), 64'd1);
        chk("t4_saborted", 64'(bus.seq_aborted), 64'd1);
        chk("t4_busy", 64'(bus.seq_busy), 64'd0);
        cycles(80);
        chk("t4_idx", 64'(bus.shot_idx), 64'd1);
        chk("t4_phase", 64'(bus.phase_shift), 64'd15);
        chk("t4_done", 64'(n_done), 64'd0);
        chk("t4_nabort", 64'(n_abort), 64'd1);
        chk("t4_starts", 64'(n_start), 64'd2);

        // Zero-shot run
        cfg(0, 1, 1, 0);
        clr();
        @(negedge clk) bus.cmd_start = 1'b1;
        @(negedge clk) bus.cmd_start = 1'b0;
        chk("t5_done_c1", 64'(bus.seq_done), 64'd0);
        @(negedge clk);
        chk("t5_done_c2", 64'(bus.seq_done), 64'd1);
        @(negedge clk);
        chk("t5_done_c3", 64'(bus.seq_done), 64'd0);
        chk("t5_starts", 64'(n_start), 64'd0);

        // Phase wrap
        run_len = 5;
        cfg(2, 32'hFFFF_FFF0, 32'h20, 0);
        clr();
        pulse_start();
        cycles(40);
        chk("t6_ph0", 64'(st_phase[0]), 64'hFFFF_FFF0);
        chk("t6_ph1", 64'(st_phase[1]), 64'h10);
        chk("t6_done", 64'(n_done), 64'd1);

        // Reset asserted inside holdoff
        cfg(3, 200, 4, 10);
        clr();
        pulse_start();
        wait_starts(1, 20);
        cycles(12);
        rst_n = 1'b0;
        #1;
        chk("t7_flags", 64'(flags()), 64'h0);
        chk("t7_phase", 64'(bus.phase_shift), 64'h0);
        chk("t7_idx", 64'(bus.shot_idx), 64'h0);
        cycles(2);
        chk("t7_noabort", 64'(n_abort), 64'd0);
        rst_n = 1'b1;
        clr();
        pulse_start();
        cycles(100);
        chk("t7_starts", 64'(n_start), 64'd3);
        chk("t7_ph2", 64'(st_phase[2]), 64'd208);
        chk("t7_done", 64'(n_done), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
